// File: rtl/psum_readout_acc.sv
// psum_readout_acc: walks pmem and sums len_kij partial sums per output pixel.
// Optional RELU_EN macro clamps negative lanes of each finished row to zero.
module psum_readout_acc #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int a_dim   = 6,
  parameter int o_dim   = 4,
  parameter int k_dim   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   readout_start,
  output logic                   CEN_pmem,
  output logic                   WEN_pmem,
  output logic [10:0]            A_pmem,
  input  logic [psum_bw*col-1:0] Q_pmem,
  output logic [psum_bw*col-1:0] readout,
  output logic                   readout_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int len_onij = o_dim * o_dim;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  logic [4:0] o;
  logic [3:0] kij;

  logic tag_vld;
  logic tag_first;
  logic tag_last;
  logic tag_end;

  logic signed [psum_bw-1:0] acc [col];
  logic signed [psum_bw-1:0] sum [col];
  logic [psum_bw*col-1:0] post;

  int oi;
  int ki;
  int addr;

  assign WEN_pmem = 1'b1;
  assign CEN_pmem = (state != RUN);

  // Address of the psum feeding (output pixel o, kernel position kij)
  always_comb begin
    oi = int'(o);
    ki = int'(kij);
    addr = ki * len_nij
         + (oi / o_dim + ki / k_dim) * a_dim
         + (oi % o_dim + ki % k_dim);
    A_pmem = (state == RUN) ? 11'(addr) : 11'd0;
  end

  // Lane-wise running sum and output post-processing
  always_comb begin
    sum = '{default: '0};
    post = '0;
    for (int c = 0; c < col; c++) begin
      sum[c] = (tag_first ? '0 : acc[c])
             + $signed(Q_pmem[c*psum_bw +: psum_bw]);
`ifdef RELU_EN
      post[c*psum_bw +: psum_bw] =
        sum[c][psum_bw-1] ? '0 : sum[c];
`else
      post[c*psum_bw +: psum_bw] = sum[c];
`endif
    end
  end

  // Issue FSM: one pmem read per cycle, tags delayed to match Q_pmem
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      o <= '0;
      kij <= '0;
      tag_vld <= 1'b0;
      tag_first <= 1'b0;
      tag_last <= 1'b0;
      tag_end <= 1'b0;
    end else begin
      tag_vld <= (state == RUN);
      tag_first <= (state == RUN) && (kij == 4'd0);
      tag_last <= (state == RUN)
               && (int'(kij) == len_kij - 1);
      tag_end <= (state == RUN)
              && (int'(kij) == len_kij - 1)
              && (int'(o) == len_onij - 1);
      unique case (state)
        IDLE: begin
          if (readout_start) begin
            state <= RUN;
            o <= '0;
            kij <= '0;
          end
        end
        RUN: begin
          if (int'(kij) == len_kij - 1) begin
            kij <= '0;
            if (int'(o) == len_onij - 1) begin
              state <= DRAIN;
            end else begin
              o <= o + 5'd1;
            end
          end else begin
            kij <= kij + 4'd1;
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulate returning data and publish each finished row
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '{default: '0};
      readout <= '0;
      readout_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      readout_valid <= 1'b0;
      done <= 1'b0;
      if (state == IDLE && readout_start) begin
        busy <= 1'b1;
      end
      if (tag_vld) begin
        acc <= sum;
        if (tag_last) begin
          readout <= post;
          readout_valid <= 1'b1;
        end
        if (tag_end) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_readout_acc.sv
// tb_psum_readout_acc: directed vectors against a behavioural pmem.
// Expected row values are hand-derived from the address pattern.
module tb_psum_readout_acc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         readout_start = 1'b0;
  logic         CEN_pmem;
  logic         WEN_pmem;
  logic [10:0]  A_pmem;
  logic [127:0] Q_pmem = '0;
  logic [127:0] readout;
  logic         readout_valid;
  logic         busy;
  logic         done;

  logic [127:0] mem [512];

  int nvec = 0;
  int nbad = 0;

  psum_readout_acc dut (
    .clk(clk),
    .reset(reset),
    .readout_start(readout_start),
    .CEN_pmem(CEN_pmem),
    .WEN_pmem(WEN_pmem),
    .A_pmem(A_pmem),
    .Q_pmem(Q_pmem),
    .readout(readout),
    .readout_valid(readout_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEN_pmem) Q_pmem <= mem[A_pmem[8:0]];
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"},
        {CEN_pmem, WEN_pmem, A_pmem,
         readout_valid, busy, done},
        {1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0});
    chk({tag, "_row"}, readout, 128'd0);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: mem[i] = {8{16'(i)}};
        1: mem[i] = {8{16'hFFFB}};
        default: mem[i] = {8{16'h7FFF}};
      endcase
    end
  endtask

  function automatic logic [127:0] exp_row(input int mode,
                                           input int r);
    logic [15:0] v;
    case (mode)
      0: v = 16'(1359 + 9 * (6 * (r / 4) + r % 4));
`ifdef RELU_EN
      1: v = 16'h0000;
`else
      1: v = 16'hFFD3;
`endif
      default: v = 16'h7FF7;
    endcase
    return {8{v}};
  endfunction

  task automatic run(input int mode,
                     input bit chk_addr,
                     input bit dbl,
                     input int abort_row);
    int row0a [9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    int rows;
    int dones;
    rows = 0;
    dones = 0;
    fill(mode);
    @(negedge clk);
    readout_start = 1'b1;
    @(posedge clk);
    #1;
    readout_start = 1'b0;
    for (int cyc = 0; cyc <= 170; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      readout_start = 1'b0;
      if (chk_addr && cyc < 9)
        chk("addr", {CEN_pmem, A_pmem},
            {1'b0, 11'(row0a[cyc])});
      if (cyc == 5) chk("busy_run", busy, 1'b1);
      if (dbl && cyc == 2) readout_start = 1'b1;
      if (readout_valid) begin
        chk("vtime", cyc, 10 + 9 * rows);
        chk("row", readout, exp_row(mode, rows));
        chk("done", done, rows == 15);
        rows++;
      end else if (done) begin
        chk("done_stray", done, 1'b0);
      end
      if (done) dones++;
      if (abort_row >= 0 && rows == abort_row + 1) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset("abort");
        return;
      end
    end
    chk("rows", rows, 16);
    chk("dones", dones, 1);
    chk("busy_end", busy, 1'b0);
  endtask

  initial begin
    repeat (10) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("idle");

    run(0, 1'b1, 1'b0, -1);
    run(1, 1'b0, 1'b0, -1);
    run(2, 1'b0, 1'b0, -1);
    run(0, 1'b0, 1'b1, -1);
    run(0, 1'b0, 1'b0, 7);
    run(0, 1'b1, 1'b0, -1);

    @(negedge clk);
    reset = 1'b1;
    readout_start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    readout_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst_wins");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
